// File: rtl/dm_sized.sv
// dm_sized: byte-addressed little-endian data memory with sized loads/stores,
// alignment/range checking, optional registered read port and a post-reset clear sweep.
module dm_sized #(
    parameter int DEPTH_BYTES    = 12288,
    parameter int ADDR_W         = 14,
    parameter int READ_LATENCY   = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       dout,
    output logic              rvalid,
    output logic              err,
    output logic              err_sticky,
    output logic              busy
);
    localparam int IW = $clog2(DEPTH_BYTES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_BYTES);
    localparam logic [IW-1:0] LAST_PTR = IW'(DEPTH_BYTES - 4);

    typedef enum logic {CLEAR, READY} state_t;

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic          r_busy;
    logic          r_err_sticky;
    logic          r_rvalid;
    logic [31:0]   r_dout;
    logic [7:0]    r_mem [DEPTH_BYTES];

    logic          w_ready;
    logic          w_err;
    logic [3:0]    w_lanes;
    logic [ADDR_W:0] w_end;
    logic [31:0]   w_raw;
    logic [31:0]   w_load;

    // Range check is done one bit wider than addr so addr+3 cannot wrap.
    always_comb begin
        w_ready = rst_n && r_state == READY;
        w_lanes = size == 2'b00 ? 4'b0001 : size == 2'b01 ? 4'b0011 : 4'b1111;
        w_end   = {1'b0, addr} + (ADDR_W+1)'(size == 2'b00 ? 1 : size == 2'b01 ? 2 : 4);
        w_err   = size == 2'b11 || (size == 2'b01 && addr[0]) ||
                  (size == 2'b10 && addr[1:0] != 2'b00) || w_end > DEPTH_L;
        w_raw   = '0;
        for (int k = 0; k < 4; k++)
            w_raw[8*k +: 8] = r_mem[addr[IW-1:0] + IW'(k)];
        w_load  = w_err ? '0 :
                  size == 2'b00 ? {{24{sign_ext & w_raw[7]}}, w_raw[7:0]} :
                  size == 2'b01 ? {{16{sign_ext & w_raw[15]}}, w_raw[15:0]} : w_raw;
    end

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            for (int k = 0; k < 4; k++)
                r_mem[r_ptr + IW'(k)] <= '0;
        end else if (w_ready && we && !w_err) begin
            for (int k = 0; k < 4; k++)
                if (w_lanes[k]) r_mem[addr[IW-1:0] + IW'(k)] <= din[8*k +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= CLEAR_ON_RESET != 0 ? CLEAR : READY;
            r_busy       <= CLEAR_ON_RESET != 0;
            r_ptr        <= '0;
            r_err_sticky <= 1'b0;
            r_rvalid     <= 1'b0;
            r_dout       <= '0;
        end else if (r_state == CLEAR) begin
            r_ptr    <= r_ptr + IW'(4);
            r_rvalid <= 1'b0;
            if (r_ptr == LAST_PTR) begin
                r_state <= READY;
                r_busy  <= 1'b0;
            end
        end else begin
            if ((we || re) && w_err) r_err_sticky <= 1'b1;
            r_rvalid <= re;
            if (re) r_dout <= w_load;
        end
    end

    always_comb begin
        dout       = READ_LATENCY != 0 ? r_dout : (w_ready ? w_load : '0);
        rvalid     = READ_LATENCY != 0 ? r_rvalid : (re & w_ready);
        err        = w_ready & w_err;
        err_sticky = r_err_sticky;
        busy       = r_busy;
    end
endmodule

// File: tb/tb_dm_sized.sv
// tb_dm_sized: directed checks of dm_sized with a combinational-read and a registered-read
// instance sharing the same stimulus (64-byte array, 7-bit address).
module tb_dm_sized;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  addr = '0;
    logic [31:0] din = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  size = '0;
    logic        sign_ext = 1'b0;
    logic [31:0] dout0, dout1;
    logic        rvalid0, rvalid1, err0, err1, errs0, errs1, busy0, busy1;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    dm_sized #(.DEPTH_BYTES(64), .ADDR_W(7), .READ_LATENCY(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .re(re), .size(size),
        .sign_ext(sign_ext), .dout(dout0), .rvalid(rvalid0), .err(err0), .err_sticky(errs0), .busy(busy0));

    dm_sized #(.DEPTH_BYTES(64), .ADDR_W(7), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .we(we), .re(re), .size(size),
        .sign_ext(sign_ext), .dout(dout1), .rvalid(rvalid1), .err(err1), .err_sticky(errs1), .busy(busy1));

    task automatic do_store(input logic [6:0] a, input logic [31:0] d, input logic [1:0] s);
        addr = a; din = d; size = s; we = 1'b1; re = 1'b0;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic set_load(input logic [6:0] a, input logic [1:0] s, input logic se);
        addr = a; size = s; sign_ext = se; re = 1'b1; we = 1'b0;
        #4;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        while (busy0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        #12;
        checks++; if ({dout0, rvalid0, err0, errs0, busy0} !== {32'h0, 4'b0001}) $display("FAIL reset_out0 got %h exp %h", {dout0, rvalid0, err0, errs0, busy0}, {32'h0, 4'b0001}); else passed++;
        checks++; if ({dout1, rvalid1, err1, errs1, busy1} !== {32'h0, 4'b0001}) $display("FAIL reset_out1 got %h exp %h", {dout1, rvalid1, err1, errs1, busy1}, {32'h0, 4'b0001}); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_sweep(n);
        checks++; if (n !== 16) $display("FAIL sweep_len got %0d exp 16", n); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL sweep_busy1 got %b exp 0", busy1); else passed++;
        for (int a = 0; a < 64; a += 4) begin
            set_load(7'(a), 2'b10, 1'b0);
            checks++; if (dout0 !== 32'h0) $display("FAIL clear_word_%0d got %h exp 0", a, dout0); else passed++;
            next_cycle();
        end
    endtask

    task automatic test_word_bytes();
        logic [31:0] exp_b [4] = '{32'h78, 32'h56, 32'h34, 32'h12};
        do_store(7'h10, 32'h12345678, 2'b10);
        for (int i = 0; i < 4; i++) begin
            set_load(7'(16 + i), 2'b00, 1'b0);
            checks++; if (dout0 !== exp_b[i]) $display("FAIL lbu_%0d got %h exp %h", i, dout0, exp_b[i]); else passed++;
            next_cycle();
        end
        set_load(7'h10, 2'b10, 1'b1);
        checks++; if (dout0 !== 32'h12345678) $display("FAIL lw_10 got %h exp 12345678", dout0); else passed++;
        checks++; if (rvalid0 !== 1'b1 || err0 !== 1'b0) $display("FAIL lw_10_flags got %b%b exp 10", rvalid0, err0); else passed++;
        next_cycle();
        set_load(7'h10, 2'b01, 1'b0);
        checks++; if (dout0 !== 32'h00005678) $display("FAIL lhu_10 got %h exp 00005678", dout0); else passed++;
        next_cycle();
        set_load(7'h12, 2'b01, 1'b1);
        checks++; if (dout0 !== 32'h00001234) $display("FAIL lh_12 got %h exp 00001234", dout0); else passed++;
        next_cycle();
    endtask

    task automatic test_byte_merge();
        do_store(7'h20, 32'hFFFFFFFF, 2'b10);
        do_store(7'h21, 32'h000000A5, 2'b00);
        set_load(7'h20, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'hFFFFA5FF) $display("FAIL merge_word got %h exp FFFFA5FF", dout0); else passed++;
        next_cycle();
        set_load(7'h21, 2'b00, 1'b1);
        checks++; if (dout0 !== 32'hFFFFFFA5) $display("FAIL lb_21 got %h exp FFFFFFA5", dout0); else passed++;
        next_cycle();
        set_load(7'h21, 2'b00, 1'b0);
        checks++; if (dout0 !== 32'h000000A5) $display("FAIL lbu_21 got %h exp 000000A5", dout0); else passed++;
        next_cycle();
        set_load(7'h20, 2'b01, 1'b1);
        checks++; if (dout0 !== 32'hFFFFA5FF) $display("FAIL lh_20 got %h exp FFFFA5FF", dout0); else passed++;
        next_cycle();
        set_load(7'h20, 2'b01, 1'b0);
        checks++; if (dout0 !== 32'h0000A5FF) $display("FAIL lhu_20 got %h exp 0000A5FF", dout0); else passed++;
        next_cycle();
    endtask

    task automatic test_misaligned();
        checks++; if (errs0 !== 1'b0) $display("FAIL sticky_pre got %b exp 0", errs0); else passed++;
        addr = 7'h03; din = 32'h0000BEEF; size = 2'b01; we = 1'b1;
        #4;
        checks++; if (err0 !== 1'b1) $display("FAIL err_half_03 got %b exp 1", err0); else passed++;
        @(posedge clk); #1;
        addr = 7'h22; din = 32'h0; size = 2'b10;
        #4;
        checks++; if (err0 !== 1'b1) $display("FAIL err_word_22 got %b exp 1", err0); else passed++;
        @(posedge clk); #1;
        addr = 7'h00; din = 32'hFFFFFFFF; size = 2'b11;
        #4;
        checks++; if (err0 !== 1'b1) $display("FAIL err_rsvd got %b exp 1", err0); else passed++;
        @(posedge clk); #1;
        we = 1'b0;
        set_load(7'h00, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'h0) $display("FAIL nowrite_0 got %h exp 0", dout0); else passed++;
        next_cycle();
        set_load(7'h20, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'hFFFFA5FF) $display("FAIL nowrite_20 got %h exp FFFFA5FF", dout0); else passed++;
        next_cycle();
        set_load(7'h22, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'h0 || err0 !== 1'b1) $display("FAIL errload_22 got %h/%b exp 0/1", dout0, err0); else passed++;
        next_cycle();
        checks++; if (errs0 !== 1'b1 || errs1 !== 1'b1) $display("FAIL sticky_set got %b%b exp 11", errs0, errs1); else passed++;
    endtask

    task automatic test_range();
        set_load(7'd63, 2'b00, 1'b0);
        checks++; if (err0 !== 1'b0) $display("FAIL err_byte_63 got %b exp 0", err0); else passed++;
        next_cycle();
        set_load(7'd62, 2'b01, 1'b0);
        checks++; if (err0 !== 1'b0) $display("FAIL err_half_62 got %b exp 0", err0); else passed++;
        next_cycle();
        do_store(7'd60, 32'hCAFEBABE, 2'b10);
        set_load(7'd60, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'hCAFEBABE || err0 !== 1'b0) $display("FAIL lw_60 got %h/%b exp CAFEBABE/0", dout0, err0); else passed++;
        next_cycle();
        set_load(7'd62, 2'b10, 1'b0);
        checks++; if (err0 !== 1'b1) $display("FAIL err_word_62 got %b exp 1", err0); else passed++;
        next_cycle();
        set_load(7'd64, 2'b00, 1'b0);
        checks++; if (err0 !== 1'b1) $display("FAIL err_byte_64 got %b exp 1", err0); else passed++;
        next_cycle();
        do_store(7'd64, 32'h000000A5, 2'b00);
        do_store(7'd62, 32'h11111111, 2'b10);
        set_load(7'h00, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'h0) $display("FAIL oor_nowrite_0 got %h exp 0", dout0); else passed++;
        next_cycle();
        set_load(7'd60, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'hCAFEBABE) $display("FAIL oor_nowrite_60 got %h exp CAFEBABE", dout0); else passed++;
        next_cycle();
    endtask

    task automatic test_mid_sweep();
        int n;
        rst_n = 1'b0;
        #2;
        checks++; if (errs0 !== 1'b0 || busy0 !== 1'b1) $display("FAIL rst_sticky got %b%b exp 01", errs0, busy0); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        addr = 7'h40; size = 2'b10; re = 1'b1; we = 1'b1; din = 32'hA5A5A5A5;
        #2;
        checks++; if (busy0 !== 1'b1) $display("FAIL midsweep_busy got %b exp 1", busy0); else passed++;
        checks++; if ({dout0, rvalid0, err0} !== 34'h0) $display("FAIL midsweep_out got %h exp 0", {dout0, rvalid0, err0}); else passed++;
        addr = 7'h10;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        count_sweep(n);
        we = 1'b0; re = 1'b0;
        checks++; if (n !== 16) $display("FAIL restart_len got %0d exp 16", n); else passed++;
        checks++; if (rvalid1 !== 1'b0 || errs0 !== 1'b0) $display("FAIL restart_flags got %b%b exp 00", rvalid1, errs0); else passed++;
        set_load(7'h10, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'h0) $display("FAIL sweep_ignores_we got %h exp 0", dout0); else passed++;
        next_cycle();
        set_load(7'h20, 2'b10, 1'b0);
        checks++; if (dout0 !== 32'h0) $display("FAIL sweep_cleared_20 got %h exp 0", dout0); else passed++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_store(7'h10, 32'h12345678, 2'b10);
        set_load(7'h10, 2'b10, 1'b0);
        checks++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b1) $display("FAIL rl1_pre got %b%b exp 01", rvalid1, rvalid0); else passed++;
        next_cycle();
        checks++; if (dout1 !== 32'h12345678 || rvalid1 !== 1'b1) $display("FAIL rl1_n1 got %h/%b exp 12345678/1", dout1, rvalid1); else passed++;
        @(posedge clk); #1;
        checks++; if (dout1 !== 32'h12345678 || rvalid1 !== 1'b0) $display("FAIL rl1_n2 got %h/%b exp 12345678/0", dout1, rvalid1); else passed++;
        addr = 7'h10; size = 2'b10; din = 32'hDEADBEEF; we = 1'b1; re = 1'b1;
        #4;
        checks++; if (dout0 !== 32'h12345678) $display("FAIL rl0_old got %h exp 12345678", dout0); else passed++;
        @(posedge clk); #1;
        we = 1'b0;
        checks++; if (dout1 !== 32'h12345678) $display("FAIL rl1_old got %h exp 12345678", dout1); else passed++;
        @(posedge clk); #1;
        checks++; if (dout1 !== 32'hDEADBEEF || rvalid1 !== 1'b1) $display("FAIL rl1_new got %h/%b exp DEADBEEF/1", dout1, rvalid1); else passed++;
        addr = 7'h13; size = 2'b00; sign_ext = 1'b1;
        @(posedge clk); #1;
        re = 1'b0;
        checks++; if (dout1 !== 32'hFFFFFFDE) $display("FAIL rl1_lb got %h exp FFFFFFDE", dout1); else passed++;
        addr = 7'h40; size = 2'b10; re = 1'b1;
        @(posedge clk); #1;
        re = 1'b0;
        checks++; if (dout1 !== 32'h0 || errs1 !== 1'b1) $display("FAIL rl1_err got %h/%b exp 0/1", dout1, errs1); else passed++;
    endtask

    initial begin
        test_reset();
        test_word_bytes();
        test_byte_merge();
        test_misaligned();
        test_range();
        test_mid_sweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
